// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter merging NUM_REQ valid/ready beat streams into one stream.
// Optional STREAM_ARB_TAG_EN adds o_out_tag, the binary index of the granted requester.
module stream_rr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic                        s_clk,
  input  logic                        s_rst,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic                        o_out_valid,
  output logic [DATA_W-1:0]           o_out_data,
  output logic                        o_out_last,
  input  logic                        i_out_ready,
  output logic [NUM_REQ-1:0]          o_grant,
`ifdef STREAM_ARB_TAG_EN
  output logic [$clog2(NUM_REQ)-1:0]  o_out_tag,
`endif
  output logic                        o_busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IdxW-1:0]    gidx_q;
  logic [IdxW-1:0]    last_q;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;

  logic               found;
  logic [IdxW-1:0]    pick;
  logic               last_cnt;
  logic               handshake;

  // Scan starts one past the previous winner, so it becomes lowest priority.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      if (!found && i_req_valid[idx]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  // Grant is all-zero outside a burst, so the merged outputs fall to zero there.
  always_comb begin
    o_out_data  = '0;
    o_out_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        o_out_data  = o_out_data | i_req_data[k*DATA_W +: DATA_W];
        o_out_valid = o_out_valid | i_req_valid[k];
      end
    end
  end

  assign last_cnt    = (cnt_q == CntW'(BURST_LEN - 1));
  assign handshake   = o_out_valid & i_out_ready;
  assign o_out_last  = o_out_valid & last_cnt;
  assign o_req_ready = grant_q & {NUM_REQ{i_out_ready}};
  assign o_grant     = grant_q;
  assign o_busy      = busy_q;

`ifdef STREAM_ARB_TAG_EN
  assign o_out_tag = busy_q ? gidx_q : '0;
`endif

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            grant_q <= NUM_REQ'(1) << pick;
            gidx_q  <= pick;
            busy_q  <= 1'b1;
            state_q <= StBurst;
          end
        end
        StBurst: begin
          if (handshake) begin
            if (last_cnt) begin
              last_q  <= gidx_q;
              cnt_q   <= '0;
              grant_q <= '0;
              gidx_q  <= '0;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
